// File: rtl/elevator_pkg.sv
// Shared types for the elevator controller front end and central FSM.
// Holds key codes, controller states, settings and keypad FSM states.
package elevator_pkg;

    typedef enum logic [3:0] {
        STOP   = 4'hA,
        RESUME = 4'hB,
        UP     = 4'hC,
        DOWN   = 4'hD,
        ESCAPE = 4'hE,
        ENTER  = 4'hF
    } button_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVING,
        S_DOORS,
        S_SETUP
    } state_e;

    typedef enum logic [1:0] {
        SET_NONE,
        SET_FLOOR,
        SET_SPEED,
        SET_DOOR
    } setting_e;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        HELD,
        RELEASE
    } kp_state_e;

    // Index of the highest set bit; 0 when no bit is set.
    function automatic logic [3:0] hi_index(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// Async active-high reset clears both stages.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_sync.sv
// Keypad front end: synchronise, debounce and priority-encode 16 keys.
// Emits one registered strobe with its key code per debounced press.
module keypad_sync
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] keys,
    output logic [3:0]  buttonBus,
    output logic        pressed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [15:0] keys_sync;
    logic [3:0]  code;
    logic        any;

    kp_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]  cap_q, cap_d;
    logic        pressed_q, pressed_d;
    logic [3:0]  bus_q, bus_d;

    sync_2ff #(.WIDTH(16)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (keys),
        .q   (keys_sync)
    );

    assign code = hi_index(keys_sync);
    assign any  = |keys_sync;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_d     = cap_q;
        pressed_d = 1'b0;
        bus_d     = 4'h0;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                    cap_d   = code;
                end
            end
            CHECK: begin
                if (!any) begin
                    state_d = IDLE;
                end else if (code != cap_q) begin
                    cnt_d = '0;
                    cap_d = code;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = HELD;
                    pressed_d = 1'b1;
                    bus_d     = cap_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // Any key activity while held is ignored until a full release.
            HELD: begin
                if (!any) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            RELEASE: begin
                if (any) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cap_q     <= 4'h0;
            pressed_q <= 1'b0;
            bus_q     <= 4'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cap_q     <= cap_d;
            pressed_q <= pressed_d;
            bus_q     <= bus_d;
        end
    end

    assign pressed   = pressed_q;
    assign buttonBus = bus_q;

endmodule

// File: tb/tb_keypad_sync.sv
// Bench for keypad_sync: run-length reference model plus directed scenarios.
// Random key bursts are checked every cycle against the model.
module tb_keypad_sync;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = 16'h0;
    logic [3:0]  buttonBus;
    logic        pressed;

    keypad_sync #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .keys      (keys),
        .buttonBus (buttonBus),
        .pressed   (pressed)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int strobes = 0;
    int strobe_cyc = -1;
    int strobe_bus = -1;

    logic       ep = 1'b0;
    logic [3:0] eb = 4'h0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int top_key(input logic [15:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 16; i++) if (v[i]) r = i;
        return r;
    endfunction

    always @(posedge clk) cyc++;

    // Reference: a press is accepted when the synchronised code has been
    // identical and non-zero for D+1 samples while armed; re-arming needs
    // D+1 consecutive all-zero samples.
    initial begin
        logic [15:0] s1, s2, samp;
        int run, zrun, pc, c;
        bit armed;
        s1 = 0; s2 = 0; run = 0; zrun = 0; pc = 0; armed = 1;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                s1 = 0; s2 = 0; run = 0; zrun = 0; pc = 0; armed = 1;
                ep = 0; eb = 0;
            end else begin
                samp = s2;
                s2 = s1;
                s1 = keys;
                ep = 0;
                eb = 0;
                if (samp == 0) begin
                    run = 0;
                    zrun++;
                    if (!armed && zrun == D + 1) armed = 1;
                end else begin
                    zrun = 0;
                    c = top_key(samp);
                    if (run > 0 && c == pc) run++;
                    else run = 1;
                    pc = c;
                    if (armed && run == D + 1) begin
                        ep = 1;
                        eb = 4'(c);
                        armed = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("pressed", int'(pressed), int'(ep));
        chk("buttonBus", int'(buttonBus), int'(eb));
        if (pressed) begin
            strobes++;
            strobe_cyc = cyc;
            strobe_bus = int'(buttonBus);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int s0, n;
        wait_cyc(3);
        chk("reset_pressed", int'(pressed), 0);
        chk("reset_bus", int'(buttonBus), 0);
        @(negedge clk);
        #2 rst = 1'b0;

        // Idle
        s0 = strobes;
        wait_cyc(100);
        chk("idle_strobes", strobes - s0, 0);

        // Clean press of key B
        s0 = strobes;
        keys = 16'h0800;
        n = cyc;
        wait_cyc(30);
        chk("clean_strobes", strobes - s0, 1);
        chk("clean_cycle", strobe_cyc, n + D + 3);
        chk("clean_bus", strobe_bus, 11);
        keys = 16'h0;
        wait_cyc(20);

        // Bouncing key 5
        s0 = strobes;
        for (int i = 0; i < 6; i++) begin
            keys = (i % 2 == 0) ? 16'h0020 : 16'h0000;
            wait_cyc(2);
        end
        keys = 16'h0020;
        n = cyc;
        wait_cyc(30);
        chk("bounce_strobes", strobes - s0, 1);
        chk("bounce_cycle", strobe_cyc, n + D + 3);
        chk("bounce_bus", strobe_bus, 5);
        keys = 16'h0;
        wait_cyc(20);

        // Priority, then key F joins while held
        s0 = strobes;
        keys = 16'h4008;
        wait_cyc(20);
        keys = 16'hC008;
        wait_cyc(20);
        chk("prio_strobes", strobes - s0, 1);
        chk("prio_bus", strobe_bus, 14);
        keys = 16'h0;
        wait_cyc(20);

        // Release debounce
        s0 = strobes;
        keys = 16'h0004;
        wait_cyc(15);
        keys = 16'h0;
        wait_cyc(2);
        keys = 16'h0004;
        wait_cyc(15);
        chk("rel_short_strobes", strobes - s0, 1);
        keys = 16'h0;
        wait_cyc(D + 4);
        keys = 16'h0004;
        wait_cyc(15);
        chk("rel_long_strobes", strobes - s0, 2);
        chk("rel_long_bus", strobe_bus, 2);
        keys = 16'h0;
        wait_cyc(20);

        // Reset mid-CHECK with key still held
        s0 = strobes;
        keys = 16'h0800;
        wait_cyc(4);
        #2 rst = 1'b1;
        #1;
        chk("rst_check_pressed", int'(pressed), 0);
        chk("rst_check_bus", int'(buttonBus), 0);
        wait_cyc(3);
        #2 rst = 1'b0;
        n = cyc;
        wait_cyc(20);
        chk("rst_check_strobes", strobes - s0, 1);
        chk("rst_check_cycle", strobe_cyc, n + D + 3);

        // Reset mid-HELD: key still held gives one fresh strobe
        s0 = strobes;
        @(negedge clk);
        #2 rst = 1'b1;
        wait_cyc(2);
        #2 rst = 1'b0;
        wait_cyc(20);
        chk("rst_held_strobes", strobes - s0, 1);
        keys = 16'h0;
        wait_cyc(20);

        // Random bursts, checked every cycle by the compare process
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: keys = 16'h0;
                1: keys = 16'(1 << $urandom_range(0, 15));
                2: keys = 16'(1 << $urandom_range(0, 15))
                        | 16'(1 << $urandom_range(0, 15));
                default: keys = 16'($urandom);
            endcase
            wait_cyc($urandom_range(1, 12));
        end
        keys = 16'h0;
        wait_cyc(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/keypad_sync.md
# keypad_sync

Front-end stage between the raw 4x4 keypad lines and `centralFSM`. It synchronises 16 asynchronous key inputs, debounces them, and priority-encodes them. It emits exactly one single-cycle `pressed` strobe, with the matching 4-bit code on `buttonBus`, per debounced key press. `centralFSM` decodes control keys (A–F) from `buttonBus` directly and gates digits with `pressed`, so `buttonBus` must be non-control whenever `pressed` is low.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised cycles required to accept a press or a release (legal range ≥ 2).
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `keys`  in  16  raw key lines; bit n high = key n held. Asynchronous to `clk`, may bounce.
- `buttonBus`  out  4  encoded key code. Valid only while `pressed`=1; otherwise 4'h0.
- `pressed`  out  1  one-cycle strobe marking an accepted press.

## Operation
- Synchronisation: every `keys` bit passes through a 2-flop synchroniser giving `keysSync[15:0]`.
- Encoding: `code` = index of the highest set bit of `keysSync` (F highest priority, 0 lowest); `any` = |`keysSync`.
- Counter `cnt`, width $clog2(DEBOUNCE_CYCLES), saturates at DEBOUNCE_CYCLES-1. Latched register `capCode[3:0]`.
- FSM states and transitions:
  - IDLE
    - `any` → CHECK, `cnt`=0, `capCode`=`code`.
  - CHECK
    - !`any` → IDLE.
    - `code`≠`capCode` → stay in CHECK, `cnt`=0, `capCode`=`code` (restart).
    - `cnt`==DEBOUNCE_CYCLES-1 → HELD, register `pressed`=1 and `buttonBus`=`capCode` for one cycle.
    - Otherwise `cnt`++.
  - HELD
    - !`any` → RELEASE, `cnt`=0.
    - Key changes while held, including new higher-priority keys, are ignored: no second strobe.
  - RELEASE
    - `any` → HELD (release bounce).
    - `cnt`==DEBOUNCE_CYCLES-1 → IDLE.
    - Otherwise `cnt`++.
- One strobe per press-release cycle; a new strobe requires a full debounced release first.
- Simultaneous keys: highest code wins. A higher key joining during CHECK restarts the debounce. Any key joining during HELD is ignored.

## Timing
- Reset values (held while `rst`=1, asynchronous): FSM=IDLE, `cnt`=0, `capCode`=0, synchroniser flops=0, `buttonBus`=4'h0, `pressed`=0.
- Outputs are registered; no combinational path from `keys`.
- Latency: with `keys` stable from before rising edge 0:
  - `keysSync` valid after edge 1.
  - CHECK entered at edge 2.
  - `pressed`=1 during the cycle after edge DEBOUNCE_CYCLES+2; low again after the next edge.
- `buttonBus` returns to 4'h0 in the same cycle `pressed` drops.
- Reset mid-CHECK or mid-HELD aborts with no strobe. After release of reset, a still-held key needs the full synchroniser plus debounce latency to be accepted.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never produces a strobe.

## Structure
- Shared package `elevator_pkg`:
  - BUTTON enum: STOP=A, RESUME=B, UP=C, DOWN=D, ESCAPE=E, ENTER=F.
  - STATE and SETTING enums, so `centralFSM` and this block use one definition.
  - Local FSM enum: IDLE, CHECK, HELD, RELEASE.
- Sub-module `sync_2ff`: parameterised-width two-flop synchroniser with async active-high reset, instantiated once at width 16. Encoder, counter and FSM stay in `keypad_sync`.

## Test plan
- Reset: assert `rst` mid-simulation with `keys`=16'h0800 → `pressed`=0 and `buttonBus`=0 immediately; no strobe until DEBOUNCE_CYCLES+2 edges after deassert.
- Clean press (DEBOUNCE_CYCLES=4): `keys`=16'h0800 held 30 cycles → `pressed`=1 with `buttonBus`=4'hB only in the cycle after edge 6; no further strobe while held.
- Bounce: key 5 toggled every 2 cycles for 12 cycles, then held → exactly one strobe, `buttonBus`=4'h5, 6 edges after the last toggle.
- Priority: `keys`=16'h4008 (keys 3 and E) → single strobe with `buttonBus`=4'hE. Key F added during HELD → no second strobe.
- Release debounce: press key 2, release for 2 cycles, re-press → one strobe total. Release for ≥4+2 cycles, then re-press → second strobe with `buttonBus`=4'h2.
- Idle check: `keys`=0 for 100 cycles → `pressed`=0 and `buttonBus`=0 throughout.
